// File: rtl/ps2_kbd_rx_if.sv
// Bus-side view of the PS/2 keyboard receiver: pop/clear strobes from the
// bus decoder and the FIFO head, ready and sticky error flags back to it.
interface ps2_kbd_rx_if;
  logic       rd;
  logic       err_clr;
  logic [7:0] kbd_data;
  logic       kbd_ready;
  logic       overflow;
  logic       frame_err;

  modport master (
    output rd,
    output err_clr,
    input  kbd_data,
    input  kbd_ready,
    input  overflow,
    input  frame_err
  );

  modport slave (
    input  rd,
    input  err_clr,
    output kbd_data,
    output kbd_ready,
    output overflow,
    output frame_err
  );
endinterface

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: synchronises the PS/2 pins, deframes 11-bit frames
// (start, 8 data LSB-first, odd parity, stop) and queues good scan codes.
module ps2_kbd_rx #(
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 100000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ps2_clk,
  input  logic             ps2_data,
  ps2_kbd_rx_if.slave      bus
);

  localparam int              AW      = $clog2(FIFO_DEPTH);
  localparam int              PW      = AW + 1;
  localparam logic [PW-1:0]   FULL_X  = PW'(FIFO_DEPTH);
  localparam logic [16:0]     TMO_LIM = 17'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
    return (^d) ^ p;
  endfunction

  logic          clk_s1_q, clk_s2_q, clk_prev_q, dat_s1_q, dat_s2_q;
  logic          fall_s, tmo_hit_s, push_req_s, ferr_set_s;
  logic          empty_s, full_s, pop_s, push_s, ovf_set_s;
  state_t        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [16:0]   tmo_q, tmo_d;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic          ready_q, ready_d, ovf_q, ovf_d, ferr_q, ferr_d;
  logic [7:0]    mem_q [FIFO_DEPTH];

  // Two-flop synchronisers plus the previous synced clock for edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
    end else begin
      clk_s1_q   <= ps2_clk;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      dat_s1_q   <= ps2_data;
      dat_s2_q   <= dat_s1_q;
    end
  end

  assign fall_s    = clk_prev_q & ~clk_s2_q;
  assign tmo_hit_s = (state_q != S_IDLE) && !fall_s && (tmo_q == TMO_LIM);

  // Deframing next-state logic
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    push_req_s = 1'b0;
    ferr_set_s = 1'b0;
    if (state_q == S_IDLE || fall_s || tmo_hit_s) begin
      tmo_d = 17'd0;
    end else begin
      tmo_d = tmo_q + 17'd1;
    end
    case (state_q)
      S_IDLE: begin
        if (fall_s && !dat_s2_q) begin
          state_d   = S_DATA;
          bit_cnt_d = 3'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DATA: begin
        if (fall_s) begin
          shift_d   = {dat_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          state_d   = (bit_cnt_q == 3'd7) ? S_PARITY : S_DATA;
        end else if (tmo_hit_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DATA;
        end
      end
      S_PARITY: begin
        if (fall_s) begin
          par_d   = dat_s2_q;
          state_d = S_STOP;
        end else if (tmo_hit_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_PARITY;
        end
      end
      S_STOP: begin
        if (fall_s) begin
          state_d = S_IDLE;
          if (odd_parity_ok(shift_q, par_q) && dat_s2_q) begin
            push_req_s = 1'b1;
          end else begin
            ferr_set_s = 1'b1;
          end
        end else if (tmo_hit_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_STOP;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM and frame registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'h00;
      par_q     <= 1'b0;
      tmo_q     <= 17'd0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      tmo_q     <= tmo_d;
    end
  end

  // A pop on a full FIFO frees the slot the simultaneous push needs
  assign empty_s   = (wr_q == rd_q);
  assign full_s    = ((wr_q ^ rd_q) == FULL_X);
  assign pop_s     = bus.rd && !empty_s;
  assign push_s    = push_req_s && (!full_s || pop_s);
  assign ovf_set_s = push_req_s && full_s && !pop_s;

  // FIFO pointer and sticky flag next-state logic
  always_comb begin
    wr_d    = push_s ? (wr_q + PW'(1)) : wr_q;
    rd_d    = pop_s  ? (rd_q + PW'(1)) : rd_q;
    ready_d = (wr_d != rd_d);
    if (ovf_set_s) begin
      ovf_d = 1'b1;
    end else if (bus.err_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
    if (ferr_set_s) begin
      ferr_d = 1'b1;
    end else if (bus.err_clr) begin
      ferr_d = 1'b0;
    end else begin
      ferr_d = ferr_q;
    end
  end

  // FIFO pointers, ready and sticky flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      ready_q <= 1'b0;
      ovf_q   <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      ready_q <= ready_d;
      ovf_q   <= ovf_d;
      ferr_q  <= ferr_d;
    end
  end

  // Scan-code storage; contents only matter between the pointers
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_q[AW-1:0]] <= shift_q;
    end
  end

  assign bus.kbd_data  = empty_s ? 8'h00 : mem_q[rd_q[AW-1:0]];
  assign bus.kbd_ready = ready_q;
  assign bus.overflow  = ovf_q;
  assign bus.frame_err = ferr_q;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Directed and randomised frames against a queue-based model of the
// receiver's visible behaviour (scan-code FIFO contents and sticky flags).
module tb_ps2_kbd_rx;

  localparam int DEPTH = 8;
  localparam int TMO   = 200;

  logic clk;
  logic rst;
  logic ps2_clk;
  logic ps2_data;

  ps2_kbd_rx_if bus ();

  ps2_kbd_rx #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clk      (clk),
    .rst      (rst),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mq [$];
  logic       m_ovf;
  logic       m_ferr;
  int         n_cmp;
  int         n_bad;

  task automatic check(input string tag);
    logic [7:0] exp_d;
    logic       exp_r;
    exp_r = (mq.size() > 0);
    exp_d = exp_r ? mq[0] : 8'h00;
    n_cmp++;
    assert (bus.kbd_ready === exp_r) else begin
      n_bad++;
      $error("FAIL %s kbd_ready got %0b expected %0b", tag, bus.kbd_ready, exp_r);
    end
    n_cmp++;
    assert (bus.kbd_data === exp_d) else begin
      n_bad++;
      $error("FAIL %s kbd_data got %02h expected %02h", tag, bus.kbd_data, exp_d);
    end
    n_cmp++;
    assert (bus.overflow === m_ovf) else begin
      n_bad++;
      $error("FAIL %s overflow got %0b expected %0b", tag, bus.overflow, m_ovf);
    end
    n_cmp++;
    assert (bus.frame_err === m_ferr) else begin
      n_bad++;
      $error("FAIL %s frame_err got %0b expected %0b", tag, bus.frame_err, m_ferr);
    end
  endtask

  // One PS/2 bit; optional rd/err_clr strobes land on the edge that acts on this bit's fall
  task automatic ps2_bit(input logic b, input logic do_rd, input logic do_clr);
    @(negedge clk); ps2_data = b;
    repeat (3) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (2) @(negedge clk);
    bus.rd = do_rd; bus.err_clr = do_clr;
    @(negedge clk);
    bus.rd = 1'b0; bus.err_clr = 1'b0;
    repeat (3) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic bad_par, input logic stop_b,
                            input logic pop_stop, input logic clr_stop);
    logic par;
    logic valid;
    par = (~(^d)) ^ bad_par;
    ps2_bit(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i], 1'b0, 1'b0);
    ps2_bit(par, 1'b0, 1'b0);
    ps2_bit(stop_b, pop_stop, clr_stop);
    valid = !bad_par && stop_b;
    if (clr_stop) begin m_ovf = 1'b0; m_ferr = 1'b0; end
    if (pop_stop && mq.size() > 0) void'(mq.pop_front());
    if (!valid) m_ferr = 1'b1;
    else if (mq.size() < DEPTH) mq.push_back(d);
    else m_ovf = 1'b1;
  endtask

  task automatic do_read();
    @(negedge clk); bus.rd = 1'b1;
    @(negedge clk); bus.rd = 1'b0;
    if (mq.size() > 0) void'(mq.pop_front());
  endtask

  task automatic do_clr();
    @(negedge clk); bus.err_clr = 1'b1;
    @(negedge clk); bus.err_clr = 1'b0;
    m_ovf = 1'b0; m_ferr = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    m_ovf = 1'b0; m_ferr = 1'b0;
    rst = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1;
    bus.rd = 1'b0; bus.err_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("reset");
    rst = 1'b1;
    repeat (3) @(negedge clk);

    send_frame(8'h1C, 1'b0, 1'b1, 1'b0, 1'b0); check("single");
    do_read(); check("single_pop");

    send_frame(8'hF0, 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0, 1'b0); check("order0");
    do_read(); check("order1");
    do_read(); check("order_empty");
    do_read(); check("rd_empty");
    send_frame(8'h33, 1'b0, 1'b1, 1'b0, 1'b0); check("after_rd_empty");
    do_read();

    send_frame(8'h1C, 1'b1, 1'b1, 1'b0, 1'b0); check("bad_parity");
    send_frame(8'h29, 1'b0, 1'b0, 1'b0, 1'b0); check("bad_stop");
    do_clr(); check("err_clr");

    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 1'b1, 1'b0, 1'b0);
    check("overflow");
    for (int i = 0; i < 8; i++) begin do_read(); check("drain"); end

    do_clr();
    for (int i = 1; i <= 8; i++) send_frame(8'(8'h10 + i), 1'b0, 1'b1, 1'b0, 1'b0);
    check("refill");
    send_frame(8'h19, 1'b0, 1'b1, 1'b1, 1'b0); check("push_pop_full");
    for (int i = 0; i < 8; i++) begin do_read(); check("drain2"); end

    send_frame(8'h44, 1'b1, 1'b1, 1'b0, 1'b1); check("set_beats_clr");
    do_clr();

    ps2_bit(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1, 1'b0, 1'b0);
    repeat (TMO + 10) @(negedge clk);
    send_frame(8'h29, 1'b0, 1'b1, 1'b0, 1'b0); check("timeout");
    do_read(); check("timeout_pop");

    send_frame(8'h1C, 1'b0, 1'b1, 1'b0, 1'b0);
    ps2_bit(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) ps2_bit(1'b1, 1'b0, 1'b0);
    @(negedge clk); rst = 1'b0;
    mq.delete(); m_ovf = 1'b0; m_ferr = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_reset");
    rst = 1'b1;
    repeat (3) @(negedge clk);
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0, 1'b0); check("after_reset");
    do_read();

    for (int it = 0; it < 40; it++) begin
      logic [7:0] d;
      d = 8'($urandom);
      send_frame(d, ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) != 0),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0));
      check("rand_frame");
      for (int r = 0; r < int'($urandom_range(0, 1)); r++) begin
        do_read(); check("rand_read");
      end
      if ($urandom_range(0, 9) == 0) begin do_clr(); check("rand_clr"); end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
